// File: rtl/key_pkg.sv
// Shared types, default 25 MHz timing constants and width helpers for the key debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } key_state_e;

    localparam int unsigned DefNumKeys        = 4;
    localparam int unsigned DefDebounceCyc    = 500000;
    localparam int unsigned DefRepeatEn       = 1;
    localparam int unsigned DefRepeatDelayCyc = 12500000;
    localparam int unsigned DefRepeatRateCyc  = 2500000;

    // Width of a counter that must hold 0 .. n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM and hold-to-repeat timer.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = DefDebounceCyc,
    parameter int unsigned REPEAT_EN        = DefRepeatEn,
    parameter int unsigned REPEAT_DELAY_CYC = DefRepeatDelayCyc,
    parameter int unsigned REPEAT_RATE_CYC  = DefRepeatRateCyc
) (
    input  logic vga_clk,
    input  logic vga_rst_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int unsigned CntW  = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned RcntW = cnt_width(max2(REPEAT_DELAY_CYC, REPEAT_RATE_CYC));

    localparam logic [CntW-1:0]  DebLast   = CntW'(DEBOUNCE_CYC - 1);
    localparam logic [RcntW-1:0] DelayLast = RcntW'(REPEAT_DELAY_CYC - 1);
    localparam logic [RcntW-1:0] RateLast  = RcntW'(REPEAT_RATE_CYC - 1);

    logic             sync_meta_q, sync_q;
    logic             pressed;
    key_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic             first_q, first_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // Raw pin is active-low; stages reset to 1 so reset looks like "released".
    assign pressed = ~sync_q;

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            sync_meta_q <= 1'b1;
            sync_q      <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            first_q     <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            sync_meta_q <= key_raw;
            sync_q      <= sync_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            first_q     <= first_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        first_d   = first_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (pressed) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!pressed) begin
                    state_d = StIdle;
                end else if (cnt_q == DebLast) begin
                    state_d = StPressed;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!pressed) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (first_q && rcnt_q == DelayLast) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                        first_d = 1'b0;
                    end else if (!first_q && rcnt_q == RateLast) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            StReleaseWait: begin
                // A bounce back to pressed resumes repeat timing from the held rcnt.
                if (pressed) begin
                    state_d = StPressed;
                end else if (cnt_q == DebLast) begin
                    state_d   = StIdle;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioning: one independent debounce channel per key plus an any-key flag.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS         = DefNumKeys,
    parameter int unsigned DEBOUNCE_CYC     = DefDebounceCyc,
    parameter int unsigned REPEAT_EN        = DefRepeatEn,
    parameter int unsigned REPEAT_DELAY_CYC = DefRepeatDelayCyc,
    parameter int unsigned REPEAT_RATE_CYC  = DefRepeatRateCyc
) (
    input  logic                vga_clk,
    input  logic                vga_rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_any
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_EN        (REPEAT_EN),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
        ) u_ch (
            .vga_clk     (vga_clk),
            .vga_rst_n   (vga_rst_n),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

    assign key_any = |key_level;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing keys against a run-length model.
module tb_key_debounce;

    localparam int unsigned NK  = 4;
    localparam int unsigned DEB = 8;
    localparam int unsigned RD  = 40;
    localparam int unsigned RR  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] raw = '1;
    logic [NK-1:0] lv0, pr0, rl0, lv1, pr1, rl1;
    logic          any0, any1;

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEYS (NK), .DEBOUNCE_CYC (DEB), .REPEAT_EN (1),
        .REPEAT_DELAY_CYC (RD), .REPEAT_RATE_CYC (RR)
    ) dut_rep (
        .vga_clk (clk), .vga_rst_n (rst_n), .key_raw (raw),
        .key_level (lv0), .key_press (pr0), .key_release (rl0), .key_any (any0)
    );

    key_debounce #(
        .NUM_KEYS (NK), .DEBOUNCE_CYC (DEB), .REPEAT_EN (0),
        .REPEAT_DELAY_CYC (RD), .REPEAT_RATE_CYC (RR)
    ) dut_norep (
        .vga_clk (clk), .vga_rst_n (rst_n), .key_raw (raw),
        .key_level (lv1), .key_press (pr1), .key_release (rl1), .key_any (any1)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // Model: a change is accepted after DEB+1 consecutive synchronised samples that differ
    // from the level; repeats fire by the number of held samples since acceptance.
    bit m_s1 [NK];
    bit m_s2 [NK];
    bit m_level [2][NK];
    bit m_press [2][NK];
    bit m_rel [2][NK];
    int m_run [2][NK];
    int m_held [2][NK];
    int m_last_press [2][NK];

    int cnt_press [2][NK];
    int cnt_rel [2][NK];

    task automatic check4(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    initial begin : model
        bit s;
        for (int k = 0; k < NK; k++) begin
            m_s1[k] = 1'b1;
            m_s2[k] = 1'b1;
        end
        forever begin
            @(posedge clk);
            edge_cnt++;
            for (int k = 0; k < NK; k++) begin
                if (!rst_n) begin
                    m_s1[k] = 1'b1;
                    m_s2[k] = 1'b1;
                    for (int d = 0; d < 2; d++) begin
                        m_level[d][k] = 1'b0;
                        m_press[d][k] = 1'b0;
                        m_rel[d][k]   = 1'b0;
                        m_run[d][k]   = 0;
                        m_held[d][k]  = 0;
                    end
                end else begin
                    s = ~m_s2[k];
                    m_s2[k] = m_s1[k];
                    m_s1[k] = raw[k];
                    for (int d = 0; d < 2; d++) begin
                        m_press[d][k] = 1'b0;
                        m_rel[d][k]   = 1'b0;
                        if (m_level[d][k] && s && m_run[d][k] == 0) begin
                            m_held[d][k]++;
                            if (d == 0 && m_held[d][k] >= RD && (m_held[d][k] - RD) % RR == 0)
                                m_press[d][k] = 1'b1;
                        end
                        if (s != m_level[d][k]) begin
                            m_run[d][k]++;
                            if (m_run[d][k] == DEB + 1) begin
                                m_level[d][k] = s;
                                m_run[d][k]   = 0;
                                if (s) begin
                                    m_press[d][k] = 1'b1;
                                    m_held[d][k]  = 0;
                                end else begin
                                    m_rel[d][k] = 1'b1;
                                end
                            end
                        end else begin
                            m_run[d][k] = 0;
                        end
                        if (m_press[d][k]) m_last_press[d][k] = edge_cnt;
                    end
                end
            end
        end
    end

    initial begin : compare
        logic [NK-1:0] el [2];
        logic [NK-1:0] ep [2];
        logic [NK-1:0] er [2];
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NK; k++) begin
                    el[d][k] = m_level[d][k];
                    ep[d][k] = m_press[d][k];
                    er[d][k] = m_rel[d][k];
                end
            end
            check4("rep_level", lv0, el[0]);
            check4("rep_press", pr0, ep[0]);
            check4("rep_release", rl0, er[0]);
            check4("rep_any", {3'b000, any0}, {3'b000, |el[0]});
            check4("norep_level", lv1, el[1]);
            check4("norep_press", pr1, ep[1]);
            check4("norep_release", rl1, er[1]);
            check4("norep_any", {3'b000, any1}, {3'b000, |el[1]});
            for (int k = 0; k < NK; k++) begin
                cnt_press[0][k] += int'(pr0[k]);
                cnt_press[1][k] += int'(pr1[k]);
                cnt_rel[0][k]   += int'(rl0[k]);
                cnt_rel[1][k]   += int'(rl1[k]);
            end
        end
    end

    function automatic logic pulse_bit(input int d, input int k, input bit rel);
        logic [NK-1:0] v;
        if (d == 0) v = rel ? rl0 : pr0;
        else        v = rel ? rl1 : pr1;
        return v[k];
    endfunction

    task automatic wait_pulse(input int d, input int k, input bit rel, input int bound,
                              output int e);
        e = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (pulse_bit(d, k, rel)) begin
                e = edge_cnt;
                return;
            end
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int n, m, e, e2, r, sp0, sp1, sr;
        int dur [NK];
        repeat (3) @(negedge clk);
        check4("reset_level", lv0, 4'b0000);
        check4("reset_press", pr0 | rl0, 4'b0000);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: clean press and release on key 0
        raw[0] = 1'b0;
        n = edge_cnt + 1;
        wait_pulse(0, 0, 1'b0, 30, e);
        check_int("t1_press_edge", e, n + 10);
        check_int("t1_model_press_edge", m_last_press[0][0], n + 10);
        check4("t1_level", lv0, 4'b0001);
        repeat (30) @(negedge clk);
        raw[0] = 1'b1;
        m = edge_cnt + 1;
        wait_pulse(0, 0, 1'b1, 30, e);
        check_int("t1_release_edge", e, m + 10);
        repeat (2) @(negedge clk);

        // 2: bounce on key 1 never accepted
        sp0 = cnt_press[0][1];
        for (int i = 0; i < 10; i++) begin
            raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) @(negedge clk);
        end
        raw[1] = 1'b1;
        repeat (15) @(negedge clk);
        check_int("t2_press_count", cnt_press[0][1] - sp0, 0);
        check4("t2_level", lv0, 4'b0000);

        // 3: short release glitch on key 2
        raw[2] = 1'b0;
        wait_pulse(0, 2, 1'b0, 30, e);
        repeat (5) @(negedge clk);
        sr = cnt_rel[0][2];
        raw[2] = 1'b1;
        repeat (4) @(negedge clk);
        raw[2] = 1'b0;
        repeat (20) @(negedge clk);
        check_int("t3_release_count", cnt_rel[0][2] - sr, 0);
        check4("t3_level", lv0, 4'b0100);
        raw[2] = 1'b1;
        wait_pulse(0, 2, 1'b1, 30, e);
        check_int("t3_release_seen", int'(e > 0), 1);

        // 4: auto-repeat on key 3
        sp0 = cnt_press[0][3];
        sp1 = cnt_press[1][3];
        raw[3] = 1'b0;
        wait_pulse(0, 3, 1'b0, 30, e);
        wait_pulse(0, 3, 1'b0, 60, e2);
        check_int("t4_first_repeat", e2 - e, 40);
        while (edge_cnt < e + 105) @(negedge clk);
        raw[3] = 1'b1;
        wait_pulse(0, 3, 1'b1, 40, m);
        repeat (3) @(negedge clk);
        check_int("t4_rep_press_count", cnt_press[0][3] - sp0, 8);
        check_int("t4_norep_press_count", cnt_press[1][3] - sp1, 1);

        // 5: all keys at once
        raw = 4'b0000;
        wait_pulse(0, 0, 1'b0, 30, e);
        check4("t5_press_all", pr0, 4'b1111);
        check4("t5_any", {3'b000, any0}, 4'b0001);
        check4("t5_norep_press_all", pr1, 4'b1111);
        repeat (10) @(negedge clk);
        raw = 4'b1111;
        repeat (20) @(negedge clk);

        // 6: reset during press-wait, key still held after reset
        raw[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check4("t6_reset_level", lv0, 4'b0000);
        check4("t6_reset_pulses", pr0 | rl0, 4'b0000);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        r = edge_cnt + 1;
        wait_pulse(0, 0, 1'b0, 30, e);
        check_int("t6_press_edge", e, r + 10);
        raw[0] = 1'b1;
        repeat (20) @(negedge clk);

        // random bouncing keys with one reset in the middle
        for (int k = 0; k < NK; k++) dur[k] = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            for (int k = 0; k < NK; k++) begin
                if (dur[k] == 0) begin
                    raw[k] = ~raw[k];
                    dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                         : $urandom_range(5, 70);
                end else begin
                    dur[k]--;
                end
            end
            if (i == 2000) #2 rst_n = 1'b0;
            if (i == 2003) #2 rst_n = 1'b1;
        end
        raw = 4'b1111;
        repeat (150) @(negedge clk);
        check4("final_idle", lv0 | lv1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
